// File: rtl/pipe_pack.sv
// Packs W_IN-bit input beats into W_DATA-bit words, lane 0 first, with s_last flushing a partial word.
// Optional word counter port o_word_cnt is enabled by defining PIPE_PACK_CNT_EN.
module pipe_pack #(
  parameter int W_DATA = 32,
  parameter int W_IN   = 8
) (
  input  logic                   i_clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [W_IN-1:0]        s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [W_DATA-1:0]      m_data,
  output logic [W_DATA/W_IN-1:0] m_keep,
  output logic                   m_last
`ifdef PIPE_PACK_CNT_EN
  ,
  output logic [15:0]            o_word_cnt
`endif
);

  localparam int N     = W_DATA / W_IN;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Handshake: a beat moves on s_valid && s_ready, a word moves on m_valid && m_ready,
  // both sampled on the rising edge of i_clk; valid never waits on ready.
  typedef enum logic {ACC = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [W_DATA-1:0]  acc_data;
  logic [N-1:0]       acc_keep;
  logic               acc_last;

  logic               accept;
  logic               complete;
  logic               out_free;
  logic [W_DATA-1:0]  word_data;
  logic [N-1:0]       word_keep;

  assign accept   = s_valid && s_ready;
  assign complete = accept && ((idx == IDX_W'(N - 1)) || s_last);
  assign out_free = !m_valid || m_ready;

  // Accumulator contents merged with the beat arriving this cycle.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        word_data[k*W_IN +: W_IN] = s_data;
        word_keep[k]              = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ACC;
      idx      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          s_ready <= 1'b1;
          if (m_valid && m_ready) m_valid <= 1'b0;
          if (complete && out_free) begin
            m_valid  <= 1'b1;
            m_data   <= word_data;
            m_keep   <= word_keep;
            m_last   <= s_last;
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
          end else if (complete) begin
            // Output register still occupied: park the finished word here.
            state    <= FULL;
            s_ready  <= 1'b0;
            acc_data <= word_data;
            acc_keep <= word_keep;
            acc_last <= s_last;
          end else if (accept) begin
            acc_data <= word_data;
            acc_keep <= word_keep;
            idx      <= idx + 1'b1;
          end
        end
        FULL: begin
          if (m_valid && m_ready) begin
            state    <= ACC;
            s_ready  <= 1'b1;
            m_data   <= acc_data;
            m_keep   <= acc_keep;
            m_last   <= acc_last;
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

`ifdef PIPE_PACK_CNT_EN
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) o_word_cnt <= '0;
    else if (m_valid && m_ready) o_word_cnt <= o_word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_pack.sv
// Directed bench for pipe_pack (W_DATA=32, W_IN=8); words are scored against an expected queue
// of {last, keep, data}. The counter test runs only when PIPE_PACK_CNT_EN is defined.
module tb_pipe_pack;
  localparam int W = 37;

  logic        i_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
`ifdef PIPE_PACK_CNT_EN
  logic [15:0] o_word_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int words    = 0;
  logic [W-1:0] exp_q[$];

  pipe_pack #(.W_DATA(32), .W_IN(8)) dut (
    .i_clk(i_clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
`ifdef PIPE_PACK_CNT_EN
    , .o_word_cnt(o_word_cnt)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // scoreboard: every word handed downstream must match the queue head
  always @(negedge i_clk) begin
    if (resetn && m_valid && m_ready) begin
      words++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $error("FAIL word_unexpected observed=%h expected=none", {m_last, m_keep, m_data});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        assert ({m_last, m_keep, m_data} === e) pass_cnt++;
        else $error("FAIL word observed=%h expected=%h", {m_last, m_keep, m_data}, e);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] d, input logic l);
    int waits;
    waits   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge i_clk);
      if (s_ready) break;
      waits++;
      if (waits > 50) begin
        check("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic last, input logic [3:0] keep, input logic [31:0] data);
    exp_q.push_back({last, keep, data});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    resetn = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int c0;
    // reset values
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_keep", 32'(m_keep), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    resetn = 1'b1;
    #1;
    check("rel_s_ready_pre_edge", 32'(s_ready), 32'd0);
    @(posedge i_clk);
    #1;
    check("rel_s_ready_first_edge", 32'(s_ready), 32'd1);

    // full word, one-cycle latency
    m_ready = 1'b1;
    push_exp(1'b0, 4'b1111, 32'h44332211);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    check("no_early_valid", 32'(m_valid), 32'd0);
    send(8'h44, 0);
    check("lat_m_valid", 32'(m_valid), 32'd1);
    check("lat_m_data", m_data, 32'h44332211);
    idle(2);
    drain("drain_full");

    // partial word flushed by s_last
    push_exp(1'b1, 4'b0011, 32'h0000BBAA);
    send(8'hAA, 0); send(8'hBB, 1);
    check("part_m_data", m_data, 32'h0000BBAA);
    check("part_m_keep", 32'(m_keep), 32'h3);
    idle(2);
    drain("drain_part");

    // s_last on the final lane
    push_exp(1'b1, 4'b1111, 32'hDDCCBBA0);
    send(8'hA0, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 1);
    idle(2);
    drain("drain_last_lane3");

    // backpressure: second word parks, input stalls
    m_ready = 1'b0;
    push_exp(1'b0, 4'b1111, 32'h04030201);
    push_exp(1'b0, 4'b1111, 32'h08070605);
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    check("stall_s_ready", 32'(s_ready), 32'd0);
    check("stall_m_valid", 32'(m_valid), 32'd1);
    idle(3);
    check("stall_hold_data", m_data, 32'h04030201);
    check("stall_hold_keep", 32'(m_keep), 32'hF);
    check("stall_still_full", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("unstall_s_ready", 32'(s_ready), 32'd1);
    check("unstall_second_word", m_data, 32'h08070605);
    drain("drain_stall");

    // reset mid-word and with a pending output
    m_ready = 1'b0;
    send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
    send(8'hF1, 0); send(8'hF2, 0);
    s_valid = 1'b0;
    resetn  = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", m_data, 32'h0);
    check("mid_rst_m_keep", 32'(m_keep), 32'd0);
    check("mid_rst_m_last", 32'(m_last), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(posedge i_clk);
    #1;
    resetn = 1'b1;
    @(posedge i_clk);
    #1;
    push_exp(1'b0, 4'b1111, 32'h04030201);
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    check("post_rst_m_data", m_data, 32'h04030201);
    idle(2);
    drain("drain_post_rst");

    // continuous input at full rate
    c0 = cyc;
    words = 0;
    push_exp(1'b0, 4'b1111, 32'h13121110);
    push_exp(1'b0, 4'b1111, 32'h17161514);
    push_exp(1'b0, 4'b1111, 32'h1B1A1918);
    for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 0);
    check("thru_cycles", 32'(cyc - c0), 32'd12);
    idle(2);
    drain("drain_thru");
    check("thru_words", 32'(words), 32'd3);

`ifdef PIPE_PACK_CNT_EN
    // word counter wraps after 65536 transfers
    do_reset();
    check("cnt_rst", 32'(o_word_cnt), 32'd0);
    for (int i = 0; i < 65535; i++) begin
      push_exp(1'b1, 4'b0001, {24'h0, 8'(i)});
      send(8'(i), 1);
    end
    idle(2);
    drain("drain_cnt");
    check("cnt_ffff", 32'(o_word_cnt), 32'hFFFF);
    push_exp(1'b1, 4'b0001, 32'h0000005A);
    send(8'h5A, 1);
    idle(2);
    check("cnt_wrap", 32'(o_word_cnt), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
